// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
// State encodings and a constant-foldable ceil(log2) helper.
package piso_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit position counter for one serialized word.
// Clear wins over enable so a reload or end of word never wraps the count.
import piso_pkg::*;

module piso_bit_counter #(
   parameter int WIDTH = 4,
   parameter int CW    = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          last
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and hold stall.
// Bit order matches a SIPO on the same clock, so it rebuilds the word.
import piso_pkg::*;

module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] par_in,
   input  logic             hold,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             in_shift;
   logic             step;
   logic             accept;
   logic             cnt_clr;

   assign in_shift = (state_q == ST_SHIFT);
   assign step     = in_shift && !hold;
   assign accept   = load_valid && load_ready;
   assign cnt_clr  = accept || (step && last);

   piso_bit_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (step),
      .cnt  (cnt),
      .last (last)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (step && last && !accept) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shift toward the output end, zero-filling the vacated bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         shreg <= '0;
      end else if (accept) begin
         shreg <= par_in;
      end else if (step) begin
         if (LSB_FIRST) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
         end else begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Ready is also gated by reset so nothing is taken while held in reset.
   assign load_ready = rst && (!in_shift || (step && last));
   assign ser_valid  = in_shift;
   assign busy       = in_shift;
   assign done       = step && last;
   assign ser_out    = in_shift &&
                       (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: 4-bit MSB-first and 8-bit LSB-first.
// A SIPO monitor on the same clock rebuilds the 4-bit stream.
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic       lv4, lr4, hold4, so4, sv4, busy4, done4;
   logic [3:0] par4;
   logic       lv8, lr8, hold8, so8, sv8, busy8, done8;
   logic [7:0] par8;
   logic [3:0] sipo = 4'h0;
   int         total = 0;
   int         bad = 0;
   logic [3:0] w4a, w4b;
   logic [7:0] w8a, w8b;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .load_valid (lv4),
      .load_ready (lr4),
      .par_in     (par4),
      .hold       (hold4),
      .ser_out    (so4),
      .ser_valid  (sv4),
      .busy       (busy4),
      .done       (done4)
   );

   piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut8 (
      .clk        (clk),
      .rst        (rst),
      .load_valid (lv8),
      .load_ready (lr8),
      .par_in     (par8),
      .hold       (hold8),
      .ser_out    (so8),
      .ser_valid  (sv8),
      .busy       (busy8),
      .done       (done8)
   );

   always @(posedge clk) begin
      if (sv4) sipo <= {sipo[2:0], so4};
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst   = 1'b0;
      lv4   = 1'b1;
      par4  = 4'hF;
      hold4 = 1'b0;
      lv8   = 1'b1;
      par8  = 8'hFF;
      hold8 = 1'b0;

      // 1. reset with load_valid asserted
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         chk("rst_ready", lr4, 1'b0);
         chk("rst_valid", sv4, 1'b0);
         chk("rst_out", so4, 1'b0);
         chk("rst_busy", busy4, 1'b0);
         chk("rst_ready8", lr8, 1'b0);
      end
      rst = 1'b1;
      lv4 = 1'b0;
      lv8 = 1'b0;
      tick();
      #1;
      chk("idle_ready", lr4, 1'b1);
      chk("idle_busy", busy4, 1'b0);

      // 2. single word 1011
      w4a  = 4'b1011;
      lv4  = 1'b1;
      par4 = w4a;
      tick();
      lv4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("s_valid", sv4, 1'b1);
         chk("s_bit", so4, w4a[3-i]);
         chk("s_done", done4, (i == 3));
         tick();
      end
      #1;
      chk("s_idle_valid", sv4, 1'b0);
      chk("s_idle_busy", busy4, 1'b0);
      chk("s_sipo", sipo, 4'b1011);

      // 3. back-to-back A then 5
      w4a  = 4'hA;
      w4b  = 4'h5;
      lv4  = 1'b1;
      par4 = w4a;
      tick();
      lv4 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            lv4  = 1'b1;
            par4 = w4b;
         end
         #1;
         chk("b_valid", sv4, 1'b1);
         chk("b_bit", so4, (i < 4) ? w4a[3-i] : w4b[7-i]);
         chk("b_done", done4, (i == 3 || i == 7));
         chk("b_ready", lr4, (i == 3 || i == 7));
         tick();
         lv4 = 1'b0;
      end
      #1;
      chk("b_end_valid", sv4, 1'b0);
      chk("b_sipo", sipo, 4'h5);

      // 4. hold for 3 cycles after first bit of C
      lv4  = 1'b1;
      par4 = 4'hC;
      tick();
      lv4 = 1'b0;
      #1;
      chk("h_bit0", so4, 1'b1);
      tick();
      hold4 = 1'b1;
      lv4   = 1'b1;
      par4  = 4'h0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("h_out", so4, 1'b1);
         chk("h_valid", sv4, 1'b1);
         chk("h_done", done4, 1'b0);
         chk("h_ready", lr4, 1'b0);
         tick();
      end
      hold4 = 1'b0;
      lv4   = 1'b0;
      #1;
      chk("h_bit1", so4, 1'b1);
      chk("h_done1", done4, 1'b0);
      tick();
      #1;
      chk("h_bit2", so4, 1'b0);
      tick();
      #1;
      chk("h_bit3", so4, 1'b0);
      chk("h_done3", done4, 1'b1);
      tick();
      #1;
      chk("h_idle", sv4, 1'b0);
      chk("h_sipo", sipo, 4'hC);

      // 5. reset mid-frame, then load 3
      lv4  = 1'b1;
      par4 = 4'hF;
      tick();
      lv4 = 1'b0;
      #1;
      chk("r_bit0", so4, 1'b1);
      tick();
      #1;
      chk("r_bit1", so4, 1'b1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("r_valid", sv4, 1'b0);
      chk("r_done", done4, 1'b0);
      chk("r_busy", busy4, 1'b0);
      chk("r_out", so4, 1'b0);
      tick();
      #1;
      chk("r_nodone", done4, 1'b0);
      chk("r_idle", sv4, 1'b0);
      w4a  = 4'h3;
      lv4  = 1'b1;
      par4 = w4a;
      tick();
      lv4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("r3_bit", so4, w4a[3-i]);
         chk("r3_done", done4, (i == 3));
         tick();
      end
      #1;
      chk("r3_sipo", sipo, 4'h3);

      // 6. WIDTH=8 LSB first: 81 then 02, ignored load mid-word
      w8a  = 8'h81;
      w8b  = 8'h02;
      lv8  = 1'b1;
      par8 = w8a;
      tick();
      lv8 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == 2) begin
            lv8  = 1'b1;
            par8 = 8'hFF;
         end
         if (i == 7) begin
            lv8  = 1'b1;
            par8 = w8b;
         end
         #1;
         chk("w8_valid", sv8, 1'b1);
         chk("w8_bit", so8, (i < 8) ? w8a[i] : w8b[i-8]);
         chk("w8_done", done8, (i == 7 || i == 15));
         chk("w8_ready", lr8, (i == 7 || i == 15));
         tick();
         if (i == 7) lv8 = 1'b0;
         if (i == 3) lv8 = 1'b0;
      end
      #1;
      chk("w8_end_valid", sv8, 1'b0);
      chk("w8_end_busy", busy8, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
